// File: rtl/logic_pipe_pkg.sv
// logic_pipe shared types.
// Operation encoding and the bitwise op helper.
package logic_pipe_pkg;

   // Widest operand the helper handles; callers zero-extend and truncate.
   localparam int MAX_W = 32;

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NAND = 2'd3
   } op_e;

   function automatic logic [MAX_W-1:0] apply_op(
      input op_e              op,
      input logic [MAX_W-1:0] a,
      input logic [MAX_W-1:0] b
   );
      logic [MAX_W-1:0] r;
      r = '0;
      unique case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// logic_pipe elastic register slice.
// Holds one beat until the downstream side takes it.
module pipe_stage
   import logic_pipe_pkg::*;
#(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready
);

   // Empty, or the held beat leaves this cycle.
   assign in_ready = !out_valid || out_ready;

   // Load on ready; data moves only with a valid beat so idle inputs never leak.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/logic_pipe.sv
// logic_pipe top: op mux, DEPTH elastic stages, occupancy counter.
// W must not exceed MAX_W from the package.
module logic_pipe
   import logic_pipe_pkg::*;
#(
   parameter  int W     = 3,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic [1:0]    op,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  y,
   output logic [CW-1:0] count
);

   logic [DEPTH-1:0]        sv;
   logic [DEPTH-1:0][W-1:0] sd;
   logic [W-1:0]            res;
   logic                    in_acc;
   logic                    out_acc;
   logic [CW-1:0]           occ;

   assign res = W'(apply_op(op_e'(op), MAX_W'(a), MAX_W'(b)));

   // Each stage owns its ready so the chain is a set of distinct nets.
   for (genvar i = 0; i < DEPTH; i++) begin : g_st
      logic         rdy;
      logic         nrdy;
      logic         iv;
      logic [W-1:0] id;

      if (i == 0) begin : g_head
         assign iv = in_valid;
         assign id = res;
      end else begin : g_body
         assign iv = sv[i-1];
         assign id = sd[i-1];
      end

      if (i == DEPTH - 1) begin : g_tail
         assign nrdy = out_ready;
      end else begin : g_link
         assign nrdy = g_st[i+1].rdy;
      end

      pipe_stage #(.W(W)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv),
         .in_data   (id),
         .in_ready  (rdy),
         .out_valid (sv[i]),
         .out_data  (sd[i]),
         .out_ready (nrdy)
      );
   end

   assign in_ready  = g_st[0].rdy;
   assign out_valid = sv[DEPTH-1];
   assign y         = sd[DEPTH-1];

   assign in_acc  = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;

   // Occupancy: +1 on accept only, -1 on drain only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (in_acc && !out_acc) begin
         count <= count + CW'(1);
      end else if (!in_acc && out_acc) begin
         count <= count - CW'(1);
      end
   end

   // Reference popcount of the stage valid bits.
   always_comb begin
      occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occ = occ + CW'(sv[i]);
      end
   end

   a_count: assert property (@(posedge clk) disable iff (rst) count == occ);

endmodule

// File: tb/tb_logic_pipe.sv
// logic_pipe bench: directed vectors on W=3/DEPTH=2,
// random traffic on W=8/DEPTH=4, queue model on both.
module tb_logic_pipe;
   import logic_pipe_pkg::*;

   localparam int D0 = 2;
   localparam int D1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Instance 0: W=3, DEPTH=2
   logic       rst0, iv0, ir0, ov0, or0;
   logic [2:0] a0, b0, y0;
   logic [1:0] op0, cnt0;

   logic_pipe #(.W(3), .DEPTH(D0)) u0 (
      .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0),
      .a(a0), .b(b0), .op(op0), .out_valid(ov0), .out_ready(or0),
      .y(y0), .count(cnt0)
   );

   // Instance 1: W=8, DEPTH=4
   logic       rst1, iv1, ir1, ov1, or1;
   logic [7:0] a1, b1, y1;
   logic [1:0] op1;
   logic [2:0] cnt1;

   logic_pipe #(.W(8), .DEPTH(D1)) u1 (
      .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .op(op1), .out_valid(ov1), .out_ready(or1),
      .y(y1), .count(cnt1)
   );

   // Model 0: FIFO of expected results plus occupancy.
   logic [2:0] q0[$];
   int         mc0 = 0;
   logic       pst0 = 1'b0;
   logic [2:0] py0 = '0;

   always @(negedge clk) begin
      if (rst0) begin
         q0.delete();
         mc0  = 0;
         pst0 = 1'b0;
      end else begin
         chk("cnt0", 32'(cnt0), mc0);
         chk("inrdy0", 32'(ir0), 32'((mc0 < D0) || or0));
         if (ov0) begin
            if (q0.size() == 0) chk("spurious0", 32'(ov0), 0);
            else                chk("y0", 32'(y0), 32'(q0[0]));
         end
         if (pst0) begin
            chk("stall_v0", 32'(ov0), 1);
            chk("stall_y0", 32'(y0), 32'(py0));
         end
         if (ov0 && or0) begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (mc0 > 0) mc0--;
         end
         if (iv0 && ir0) begin
            q0.push_back(3'(apply_op(op_e'(op0), 32'(a0), 32'(b0))));
            mc0++;
         end
         pst0 = ov0 && !or0;
         py0  = y0;
      end
   end

   // Model 1: same rules, larger pipe.
   logic [7:0] q1[$];
   int         mc1 = 0;
   int         acc1 = 0;
   logic       pst1 = 1'b0;
   logic [7:0] py1 = '0;

   always @(negedge clk) begin
      if (rst1) begin
         q1.delete();
         mc1  = 0;
         pst1 = 1'b0;
      end else begin
         chk("cnt1", 32'(cnt1), mc1);
         chk("inrdy1", 32'(ir1), 32'((mc1 < D1) || or1));
         if (ov1) begin
            if (q1.size() == 0) chk("spurious1", 32'(ov1), 0);
            else                chk("y1", 32'(y1), 32'(q1[0]));
         end
         if (pst1) begin
            chk("stall_v1", 32'(ov1), 1);
            chk("stall_y1", 32'(y1), 32'(py1));
         end
         if (ov1 && or1) begin
            if (q1.size() > 0) void'(q1.pop_front());
            if (mc1 > 0) mc1--;
         end
         if (iv1 && ir1) begin
            q1.push_back(8'(apply_op(op_e'(op1), 32'(a1), 32'(b1))));
            mc1++;
            acc1++;
         end
         pst1 = ov1 && !or1;
         py1  = y1;
      end
   end

   task automatic beat0(input logic [2:0] a, input logic [2:0] b,
                        input op_e op);
      iv0 = 1'b1;
      a0  = a;
      b0  = b;
      op0 = op;
   endtask

   initial begin
      rst0 = 1'b1; iv0 = 1'b0; or0 = 1'b0;
      a0 = '0; b0 = '0; op0 = '0;
      rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b0;
      a1 = '0; b1 = '0; op1 = '0;

      #2;
      chk("rst_ov", 32'(ov0), 0);
      chk("rst_cnt", 32'(cnt0), 0);
      chk("rst_y", 32'(y0), 0);
      tick();
      tick();
      rst0 = 1'b0;

      // Single AND beat, DEPTH-cycle latency.
      tick(); beat0(3'b110, 3'b011, OP_AND); or0 = 1'b1; #1;
      chk("t1_inrdy", 32'(ir0), 1);
      chk("t1_cnt_c0", 32'(cnt0), 0);
      tick(); iv0 = 1'b0; #1;
      chk("t1_ov_c1", 32'(ov0), 0);
      chk("t1_cnt_c1", 32'(cnt0), 1);
      tick(); #1;
      chk("t1_ov_c2", 32'(ov0), 1);
      chk("t1_y_c2", 32'(y0), 32'(3'b010));
      chk("t1_cnt_c2", 32'(cnt0), 1);
      tick(); #1;
      chk("t1_ov_c3", 32'(ov0), 0);
      chk("t1_cnt_c3", 32'(cnt0), 0);

      // Idle operands must not reach y.
      a0 = 'x; b0 = 'x;
      tick(); tick(); #1;
      chk("x_y", 32'(y0), 32'(3'b010));
      chk("x_ov", 32'(ov0), 0);

      // Back-to-back OR, XOR, NAND.
      tick(); beat0(3'b101, 3'b011, OP_OR); #1;
      tick(); op0 = OP_XOR; #1;
      chk("t2_cnt_c1", 32'(cnt0), 1);
      tick(); op0 = OP_NAND; #1;
      chk("t2_ov_c2", 32'(ov0), 1);
      chk("t2_y_c2", 32'(y0), 32'(3'b111));
      chk("t2_cnt_c2", 32'(cnt0), 2);
      tick(); iv0 = 1'b0; #1;
      chk("t2_y_c3", 32'(y0), 32'(3'b110));
      chk("t2_cnt_c3", 32'(cnt0), 2);
      tick(); #1;
      chk("t2_ov_c4", 32'(ov0), 1);
      chk("t2_y_c4", 32'(y0), 32'(3'b110));
      chk("t2_cnt_c4", 32'(cnt0), 1);
      tick(); #1;
      chk("t2_cnt_c5", 32'(cnt0), 0);

      // Full stall, then release with input held.
      tick(); or0 = 1'b0; beat0(3'b001, 3'b111, OP_AND); #1;
      chk("t3_inrdy_c0", 32'(ir0), 1);
      tick(); beat0(3'b010, 3'b100, OP_OR); #1;
      chk("t3_inrdy_c1", 32'(ir0), 1);
      chk("t3_cnt_c1", 32'(cnt0), 1);
      tick(); beat0(3'b111, 3'b010, OP_XOR); #1;
      chk("t3_inrdy_c2", 32'(ir0), 0);
      chk("t3_cnt_c2", 32'(cnt0), 2);
      chk("t3_y_c2", 32'(y0), 32'(3'b001));
      tick(); #1;
      chk("t3_inrdy_c3", 32'(ir0), 0);
      chk("t3_y_c3", 32'(y0), 32'(3'b001));
      tick(); or0 = 1'b1; #1;
      chk("t4_inrdy_full", 32'(ir0), 1);
      chk("t4_cnt_full", 32'(cnt0), 2);
      tick(); beat0(3'b011, 3'b011, OP_NAND); #1;
      chk("t4_y_c5", 32'(y0), 32'(3'b110));
      chk("t4_cnt_c5", 32'(cnt0), 2);
      tick(); iv0 = 1'b0; #1;
      chk("t4_y_c6", 32'(y0), 32'(3'b101));
      chk("t4_cnt_c6", 32'(cnt0), 2);
      tick(); #1;
      chk("t4_y_c7", 32'(y0), 32'(3'b100));
      chk("t4_cnt_c7", 32'(cnt0), 1);
      tick(); #1;
      chk("t4_ov_c8", 32'(ov0), 0);
      chk("t4_cnt_c8", 32'(cnt0), 0);

      // Reset with a full pipe.
      tick(); or0 = 1'b0; beat0(3'b111, 3'b111, OP_AND); #1;
      tick(); beat0(3'b001, 3'b000, OP_OR); #1;
      tick(); iv0 = 1'b0; #1;
      chk("t5_cnt_full", 32'(cnt0), 2);
      chk("t5_y_full", 32'(y0), 32'(3'b111));
      #1 rst0 = 1'b1;
      #1;
      chk("t5_ov_rst", 32'(ov0), 0);
      chk("t5_cnt_rst", 32'(cnt0), 0);
      chk("t5_y_rst", 32'(y0), 0);
      tick(); rst0 = 1'b0; or0 = 1'b1;
      beat0(3'b110, 3'b011, OP_XOR); #1;
      tick(); iv0 = 1'b0; #1;
      chk("t5_ov_c1", 32'(ov0), 0);
      tick(); #1;
      chk("t5_ov_c2", 32'(ov0), 1);
      chk("t5_y_c2", 32'(y0), 32'(3'b101));
      tick(); #1;
      chk("t5_ov_c3", 32'(ov0), 0);
      chk("t5_q_empty", q0.size(), 0);

      // Random traffic on the wide/deep instance.
      tick(); rst1 = 1'b0;
      for (int c = 0; c < 20000 && acc1 < 1000; c++) begin
         tick();
         iv1 = ($urandom_range(3) != 0);
         or1 = ($urandom_range(3) != 0);
         if (iv1) begin
            a1  = 8'($urandom);
            b1  = 8'($urandom);
            op1 = 2'($urandom);
         end else begin
            a1 = 'x;
            b1 = 'x;
         end
      end
      tick(); iv1 = 1'b0;
      chk("t6_accepted", 32'(acc1 >= 1000), 1);
      or1 = 1'b1;
      repeat (D1 + 2) tick();
      #1;
      chk("t6_drain_q", q1.size(), 0);
      chk("t6_drain_ov", 32'(ov1), 0);
      chk("t6_drain_cnt", 32'(cnt1), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
